// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs. loader/debug port, CPU priority with a
// bounded-starvation run counter and a loader lock mode for bulk transfers.
//
//   state  | meaning
//   SHARED | CPU has priority, loader forced through after MAX_CPU_RUN contested wins
//   LOCKED | loader owns memory exclusively, CPU always stalled
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  input  logic                  ldr_lock,
  output logic                  ldr_gnt,
  output logic                  ldr_locked,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    ST_SHARED = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_CPU_RUN);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_run_cnt;
  logic [3:0]            w_run_cnt_nxt;
  logic                  w_ldr_gnt;
  logic                  w_cpu_gnt;
  logic                  w_ldr_rd;
  logic                  r_ldr_rvalid;
  logic [DATA_WIDTH-1:0] r_ldr_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_SHARED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SHARED: if (ldr_lock)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (!ldr_lock) w_state_nxt = ST_SHARED;
      default:                  w_state_nxt = ST_SHARED;
    endcase
  end

  // Grant decision and memory-port mux; only one requester drives memory per cycle.
  always_comb begin
    w_ldr_gnt    = 1'b0;
    w_cpu_gnt    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_ldr_gnt = ldr_req;
    end else begin
      w_ldr_gnt = ldr_req && (!cpu_req || (r_run_cnt == RUN_MAX));
      w_cpu_gnt = cpu_req && !w_ldr_gnt;
    end
    if (w_ldr_gnt) begin
      mem_addr     = ldr_addr;
      mem_wdata    = ldr_wdata;
      mem_write_en = ldr_we;
      mem_read_en  = !ldr_we;
    end else if (w_cpu_gnt) begin
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      mem_write_en = cpu_we;
      mem_read_en  = !cpu_we;
    end
  end

  // Counts contested CPU wins; any loader grant or idle loader resets the streak.
  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if (w_ldr_gnt || !ldr_req) begin
      w_run_cnt_nxt = '0;
    end else if (w_cpu_gnt && (r_run_cnt != RUN_MAX)) begin
      w_run_cnt_nxt = r_run_cnt + 4'd1;
    end
  end

  assign w_ldr_rd = w_ldr_gnt && !ldr_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_cnt    <= '0;
      r_ldr_rvalid <= 1'b0;
      r_ldr_rdata  <= '0;
    end else begin
      r_run_cnt    <= w_run_cnt_nxt;
      r_ldr_rvalid <= w_ldr_rd;
      if (w_ldr_rd) begin
        r_ldr_rdata <= mem_rdata;
      end
    end
  end

  assign ldr_gnt    = w_ldr_gnt;
  assign cpu_stall  = cpu_req && !w_cpu_gnt;
  assign cpu_rdata  = mem_rdata;
  assign ldr_locked = (r_state == ST_LOCKED);
  assign ldr_rvalid = r_ldr_rvalid;
  assign ldr_rdata  = r_ldr_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset checks, directed sequences, a cycle table for
// contention/lock behaviour, and randomized traffic against a reference model.
module tb_dmem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXR = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          ldr_gnt, ldr_locked, ldr_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en, mem_write_en;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  // Simple synchronous-write, async-read memory plus a preload path.
  logic [DW-1:0] tb_mem [256];
  logic [DW-1:0] model_mem [256];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) tb_mem[pl_addr] <= pl_data;
    else if (mem_write_en) tb_mem[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = tb_mem[mem_addr[7:0]];

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_CPU_RUN(MAXR)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_locked(ldr_locked),
    .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic cr, cw, lr, lw, lk;
    logic e_stall, e_lgnt, e_locked;
  } vec_t;

  vec_t vt [28];

  function automatic vec_t mk(logic cr, logic cw, logic lr, logic lw, logic lk,
                              logic es, logic eg, logic el);
    vec_t v;
    v.cr = cr; v.cw = cw; v.lr = lr; v.lw = lw; v.lk = lk;
    v.e_stall = es; v.e_lgnt = eg; v.e_locked = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      pl_en   = 1'b1;
      pl_addr = 8'(i);
      pl_data = (i == 16) ? 32'h0000_00A5 : (i == 64) ? 32'hDEAD_BEEF : $urandom;
      model_mem[i] = pl_data;
      nxt();
    end
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
  endtask

  initial begin
    logic          m_locked, m_pv, hold, lg, cg, ewe, ere;
    int            m_streak;
    logic [DW-1:0] m_prd;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;

    reset = 1'b1;
    idle_inputs();
    preload();

    chk("rst rvalid", ldr_rvalid, 0);
    chk("rst rdata", ldr_rdata, 0);
    chk("rst locked", ldr_locked, 0);
    chk("rst stall", cpu_stall, 0);
    chk("rst gnt", ldr_gnt, 0);
    chk("rst rd_en", mem_read_en, 0);
    chk("rst wr_en", mem_write_en, 0);
    reset = 1'b0;

    // CPU-only read, zero-latency data
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #1;
    chk("cpu rdata", cpu_rdata, 32'hA5);
    chk("cpu stall", cpu_stall, 0);
    chk("cpu ldr_gnt", ldr_gnt, 0);
    chk("cpu rd_en", mem_read_en, 1);
    chk("cpu addr", mem_addr, 32'h10);
    nxt();

    // Loader read, data one cycle later for one cycle only
    idle_inputs();
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h40;
    #1;
    chk("lrd gnt", ldr_gnt, 1);
    chk("lrd rvalid0", ldr_rvalid, 0);
    nxt();
    ldr_req = 0;
    #1;
    chk("lrd rvalid1", ldr_rvalid, 1);
    chk("lrd rdata1", ldr_rdata, 32'hDEADBEEF);
    nxt();
    chk("lrd rvalid2", ldr_rvalid, 0);
    chk("lrd hold", ldr_rdata, 32'hDEADBEEF);

    // CPU write then loader read of same address
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
    #1;
    chk("raw wr_en", mem_write_en, 1);
    chk("raw wdata", mem_wdata, 32'h1234);
    nxt();
    cpu_req = 0; cpu_we = 0;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h20;
    #1;
    chk("raw ldr_gnt", ldr_gnt, 1);
    nxt();
    ldr_req = 0;
    #1;
    chk("raw rdata", ldr_rdata, 32'h1234);
    chk("raw rvalid", ldr_rvalid, 1);
    nxt();

    // Contention, lock entry/exit and run counter restart
    for (int i = 0; i < 4; i++) vt[i] = mk(1,0,1,0,0, 0,0,0);
    vt[4] = mk(1,0,1,0,0, 1,1,0);
    for (int i = 5; i < 9; i++) vt[i] = mk(1,0,1,0,0, 0,0,0);
    vt[9]  = mk(1,0,1,0,0, 1,1,0);
    vt[10] = mk(1,1,0,0,0, 0,0,0);
    vt[11] = mk(0,0,1,1,0, 0,1,0);
    vt[12] = mk(1,0,1,0,1, 0,0,0);
    for (int i = 13; i < 21; i++) vt[i] = mk(1,0,1,1,1, 1,1,1);
    vt[21] = mk(1,0,0,0,1, 1,0,1);
    vt[22] = mk(1,0,1,0,0, 1,1,1);
    for (int i = 23; i < 27; i++) vt[i] = mk(1,0,1,0,0, 0,0,0);
    vt[27] = mk(1,0,1,0,0, 1,1,0);

    for (int i = 0; i < 28; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; cpu_addr = 32'h30; cpu_wdata = 32'h0C0C_0C0C;
      ldr_req = vt[i].lr; ldr_we = vt[i].lw; ldr_addr = 32'h50;
      ldr_wdata = 32'h1D1D_0000 + 32'(i); ldr_lock = vt[i].lk;
      #1;
      cg    = vt[i].cr && !vt[i].e_stall;
      ewe   = vt[i].e_lgnt ? vt[i].lw : (cg ? vt[i].cw : 1'b0);
      ere   = (vt[i].e_lgnt && !vt[i].lw) || (cg && !vt[i].cw);
      eaddr = vt[i].e_lgnt ? 32'h50 : (cg ? 32'h30 : 32'h0);
      ewd   = vt[i].e_lgnt ? ldr_wdata : (cg ? cpu_wdata : 32'h0);
      chk($sformatf("row%0d stall", i), cpu_stall, vt[i].e_stall);
      chk($sformatf("row%0d ldr_gnt", i), ldr_gnt, vt[i].e_lgnt);
      chk($sformatf("row%0d locked", i), ldr_locked, vt[i].e_locked);
      chk($sformatf("row%0d wr_en", i), mem_write_en, ewe);
      chk($sformatf("row%0d rd_en", i), mem_read_en, ere);
      chk($sformatf("row%0d addr", i), mem_addr, eaddr);
      chk($sformatf("row%0d wdata", i), mem_wdata, ewd);
      nxt();
    end

    // Reset while LOCKED with a loader read in flight
    idle_inputs();
    ldr_lock = 1; ldr_req = 1; ldr_we = 0; ldr_addr = 32'h40;
    #1;
    chk("mrst gnt0", ldr_gnt, 1);
    nxt();
    chk("mrst locked", ldr_locked, 1);
    chk("mrst rvalid", ldr_rvalid, 1);
    reset = 1'b1;
    #1;
    chk("mrst rvalid0", ldr_rvalid, 0);
    chk("mrst locked0", ldr_locked, 0);
    chk("mrst rdata0", ldr_rdata, 0);
    idle_inputs();
    #1;
    chk("mrst rd_en", mem_read_en, 0);
    chk("mrst wr_en", mem_write_en, 0);
    chk("mrst gnt", ldr_gnt, 0);
    nxt();
    preload();
    reset = 1'b0;

    // Randomized traffic against a rule-level model
    m_locked = 0; m_streak = 0; m_pv = 0; m_prd = '0; hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom);
        cpu_addr  = {24'h0, 8'($urandom)};
        cpu_wdata = $urandom;
      end
      ldr_req   = ($urandom_range(0, 2) != 0);
      ldr_we    = 1'($urandom);
      ldr_addr  = {24'h0, 8'($urandom)};
      ldr_wdata = $urandom;
      if ($urandom_range(0, 19) == 0) ldr_lock = !ldr_lock;
      #1;
      lg    = ldr_req && (m_locked || !cpu_req || (m_streak == MAXR));
      cg    = !m_locked && cpu_req && !lg;
      ewe   = lg ? ldr_we : (cg ? cpu_we : 1'b0);
      ere   = lg ? !ldr_we : (cg ? !cpu_we : 1'b0);
      eaddr = lg ? ldr_addr : (cg ? cpu_addr : '0);
      ewd   = lg ? ldr_wdata : (cg ? cpu_wdata : '0);
      chk("rnd ldr_gnt", ldr_gnt, lg);
      chk("rnd stall", cpu_stall, cpu_req && !cg);
      chk("rnd locked", ldr_locked, m_locked);
      chk("rnd wr_en", mem_write_en, ewe);
      chk("rnd rd_en", mem_read_en, ere);
      chk("rnd addr", mem_addr, eaddr);
      chk("rnd wdata", mem_wdata, ewd);
      chk("rnd rvalid", ldr_rvalid, m_pv);
      chk("rnd ldr_rdata", ldr_rdata, m_prd);
      if (cg && !cpu_we) chk("rnd cpu_rdata", cpu_rdata, model_mem[cpu_addr[7:0]]);

      m_pv = lg && !ldr_we;
      if (m_pv) m_prd = model_mem[ldr_addr[7:0]];
      if (lg && ldr_we) model_mem[ldr_addr[7:0]] = ldr_wdata;
      if (cg && cpu_we) model_mem[cpu_addr[7:0]] = cpu_wdata;
      if (lg || !ldr_req) m_streak = 0;
      else if (cg && m_streak < MAXR) m_streak++;
      m_locked = ldr_lock;
      hold = cpu_req && !cg;
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
